// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  localparam logic [3:0] SEL_ALL    = 4'hF;
  localparam int         BUS_DATA_W = 32;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts bus wait cycles; expired flags the last permitted wait cycle.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count waiting cycles; cleared whenever no transfer is outstanding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Only meaningful while still waiting, so an ack in the same cycle wins
  assign expired = run && (r_count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and the data path.
// D wins a simultaneous request unless it won the previous grant.
// DATA_W must be 32 (the bus data width).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_wmask_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_valid_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_sel_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  arb_state_t            r_state, w_state_nxt;
  logic                  r_last_grant_d, w_last_grant_d_nxt;
  logic                  r_bus_req, w_bus_req_nxt;
  logic                  r_bus_we, w_bus_we_nxt;
  logic [ADDR_W-1:0]     r_bus_addr, w_bus_addr_nxt;
  logic [DATA_W-1:0]     r_bus_wdata, w_bus_wdata_nxt;
  logic [3:0]            r_bus_sel, w_bus_sel_nxt;
  logic [DATA_W-1:0]     r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0]     r_d_rdata, w_d_rdata_nxt;
  logic                  r_if_valid, w_if_valid_nxt;
  logic                  r_d_valid, w_d_valid_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_done, w_busy, w_run, w_clear, w_expired, w_grant_d;
  logic [BUS_DATA_W-1:0] w_rdata;

  assign w_done    = bus_ack_i | bus_err_i;
  assign w_busy    = (r_state != IDLE);
  assign w_run     = w_busy & ~w_done;
  assign w_clear   = ~w_busy | w_done;
  assign w_grant_d = d_req_i & (~if_req_i | ~r_last_grant_d);
  // Read data only survives a clean load ack; stores and errors return zero
  assign w_rdata   = (bus_ack_i && !bus_err_i && !r_bus_we) ? bus_rdata_i : '0;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_clear),
    .run     (w_run),
    .expired (w_expired)
  );

  // Next-state and next-output decode; bus attributes hold unless granting
  always_comb begin
    w_state_nxt        = r_state;
    w_last_grant_d_nxt = r_last_grant_d;
    w_bus_req_nxt      = r_bus_req;
    w_bus_we_nxt       = r_bus_we;
    w_bus_addr_nxt     = r_bus_addr;
    w_bus_wdata_nxt    = r_bus_wdata;
    w_bus_sel_nxt      = r_bus_sel;
    w_if_rdata_nxt     = r_if_rdata;
    w_d_rdata_nxt      = r_d_rdata;
    w_if_valid_nxt     = 1'b0;
    w_d_valid_nxt      = 1'b0;
    w_err_nxt          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (d_req_i || if_req_i) begin
          w_bus_req_nxt = 1'b1;
          if (w_grant_d) begin
            w_state_nxt        = BUSY_D;
            w_last_grant_d_nxt = 1'b1;
            w_bus_we_nxt       = d_we_i;
            w_bus_addr_nxt     = d_addr_i;
            w_bus_wdata_nxt    = d_wdata_i;
            w_bus_sel_nxt      = d_we_i ? d_wmask_i : SEL_ALL;
          end else begin
            w_state_nxt        = BUSY_IF;
            w_last_grant_d_nxt = 1'b0;
            w_bus_we_nxt       = 1'b0;
            w_bus_addr_nxt     = if_addr_i;
            w_bus_wdata_nxt    = '0;
            w_bus_sel_nxt      = SEL_ALL;
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        if (w_done || w_expired) begin
          w_state_nxt   = IDLE;
          w_bus_req_nxt = 1'b0;
          w_err_nxt     = bus_err_i | w_expired;
          if (r_state == BUSY_IF) begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = w_rdata;
          end else begin
            w_d_valid_nxt  = 1'b1;
            w_d_rdata_nxt  = w_rdata;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b0;
      r_bus_req      <= 1'b0;
      r_bus_we       <= 1'b0;
      r_bus_addr     <= '0;
      r_bus_wdata    <= '0;
      r_bus_sel      <= '0;
      r_if_rdata     <= '0;
      r_d_rdata      <= '0;
      r_if_valid     <= 1'b0;
      r_d_valid      <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_last_grant_d <= w_last_grant_d_nxt;
      r_bus_req      <= w_bus_req_nxt;
      r_bus_we       <= w_bus_we_nxt;
      r_bus_addr     <= w_bus_addr_nxt;
      r_bus_wdata    <= w_bus_wdata_nxt;
      r_bus_sel      <= w_bus_sel_nxt;
      r_if_rdata     <= w_if_rdata_nxt;
      r_d_rdata      <= w_d_rdata_nxt;
      r_if_valid     <= w_if_valid_nxt;
      r_d_valid      <= w_d_valid_nxt;
      r_err          <= w_err_nxt;
    end
  end

  assign if_rdata_o  = r_if_rdata;
  assign if_valid_o  = r_if_valid;
  assign d_rdata_o   = r_d_rdata;
  assign d_valid_o   = r_d_valid;
  assign err_o       = r_err;
  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;
  assign bus_sel_o   = r_bus_sel;
  assign stall_if_o  = if_req_i & ~r_if_valid;
  assign stall_mem_o = d_req_i & ~r_d_valid;

  // Requesters must hold their request for the whole granted transfer
  a_if_held: assert property (@(posedge clk) disable iff (!reset_n)
                              (r_state == BUSY_IF) |-> if_req_i);
  a_d_held:  assert property (@(posedge clk) disable iff (!reset_n)
                              (r_state == BUSY_D) |-> d_req_i);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: two requesters, a bus responder that decides each
// transfer's outcome up front, and a monitor that predicts grants from the
// arbitration rule and scores every completion against the queued outcome.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int NTX = 60;

  logic          clk;
  logic          reset_n;
  logic          if_req_i, d_req_i, d_we_i;
  logic [AW-1:0] if_addr_i, d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [3:0]    d_wmask_i;
  logic [DW-1:0] if_rdata_o, d_rdata_o;
  logic          if_valid_o, d_valid_o, err_o;
  logic          bus_req_o, bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [3:0]    bus_sel_o;
  logic          bus_ack_i, bus_err_i;
  logic [DW-1:0] bus_rdata_i;
  logic          stall_if_o, stall_mem_o;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_wmask_i(d_wmask_i), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i),
    .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks, n_err, n_dv;
  bit run_rand, rst_phase, slave_quiet, if_done, d_done;

  typedef struct { bit is_d; bit we; } gnt_t;
  typedef struct { bit err; logic [31:0] rdata; int vcyc; } exp_t;
  gnt_t gnt_q[$];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder: picks ack/err/ack+err after 0..7 waits, or no answer (timeout)
  initial begin
    bit in_txn, plan_to, p_ack, p_err;
    int wait_left, late_cnt, sel;
    logic [31:0] p_data;
    exp_t e;
    in_txn = 0; plan_to = 0; wait_left = 0; late_cnt = 0;
    bus_ack_i = 0; bus_err_i = 0; bus_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus_ack_i = 0; bus_err_i = 0; bus_rdata_i = $urandom;
      if (slave_quiet || !reset_n) begin
        in_txn = 0; late_cnt = 0;
      end else begin
        if (late_cnt > 0) begin
          late_cnt--;
          if (late_cnt == 0 && !bus_req_o) bus_ack_i = 1;
        end
        if (bus_req_o) begin
          if (!in_txn) begin
            in_txn    = 1;
            sel       = $urandom_range(0, 9);
            plan_to   = (sel == 0);
            p_err     = (sel == 1) || (sel == 2);
            p_ack     = (sel != 1);
            wait_left = $urandom_range(0, TO - 1);
            p_data    = $urandom;
            e.err     = plan_to || p_err;
            e.rdata   = e.err ? 32'h0 : p_data;
            e.vcyc    = plan_to ? cyc + TO : cyc + wait_left + 1;
            exp_q.push_back(e);
          end
          if (!plan_to) begin
            if (wait_left == 0) begin
              bus_ack_i = p_ack; bus_err_i = p_err; bus_rdata_i = p_data; in_txn = 0;
            end else begin
              wait_left--;
            end
          end
        end else if (in_txn) begin
          in_txn = 0; late_cnt = 2;
        end
      end
    end
  end

  // Monitor / reference model
  initial begin
    bit prev_req, last_d, exp_d, ew;
    logic [31:0] s_addr, s_wdata;
    logic [4:0]  s_ctl;
    logic [3:0]  esel;
    logic [31:0] ea;
    gnt_t g;
    exp_t e;
    prev_req = 0; last_d = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        prev_req = 0; last_d = 0; gnt_q.delete(); exp_q.delete();
        continue;
      end
      chk("stall_if", stall_if_o, if_req_i & ~if_valid_o);
      chk("stall_mem", stall_mem_o, d_req_i & ~d_valid_o);
      chk("valid_exclusive", if_valid_o & d_valid_o, 0);
      if (!if_valid_o && !d_valid_o) chk("err_without_valid", err_o, 0);
      if (bus_req_o && !prev_req) begin
        if (!if_req_i && !d_req_i) begin
          chk("grant_without_req", bus_req_o, 0);
        end else begin
          exp_d  = d_req_i && !(if_req_i && last_d);
          last_d = exp_d;
          ew     = exp_d ? d_we_i : 1'b0;
          ea     = exp_d ? d_addr_i : if_addr_i;
          esel   = (exp_d && d_we_i) ? d_wmask_i : 4'hF;
          chk("grant_addr", bus_addr_o, ea);
          chk("grant_we", bus_we_o, ew);
          chk("grant_sel", bus_sel_o, esel);
          if (exp_d && d_we_i) chk("grant_wdata", bus_wdata_o, d_wdata_i);
          gnt_q.push_back('{is_d: exp_d, we: ew});
          s_addr = bus_addr_o; s_wdata = bus_wdata_o; s_ctl = {bus_we_o, bus_sel_o};
        end
      end else if (bus_req_o && prev_req) begin
        chk("hold_addr", bus_addr_o, s_addr);
        chk("hold_wdata", bus_wdata_o, s_wdata);
        chk("hold_ctl", {bus_we_o, bus_sel_o}, s_ctl);
      end
      if (if_valid_o || d_valid_o) begin
        if (gnt_q.size() == 0 || exp_q.size() == 0) begin
          chk("unexpected_valid", {if_valid_o, d_valid_o}, 0);
        end else begin
          g = gnt_q.pop_front();
          e = exp_q.pop_front();
          chk("valid_d_port", d_valid_o, g.is_d);
          chk("valid_if_port", if_valid_o, !g.is_d);
          chk("valid_err", err_o, e.err);
          chk("valid_rdata", g.is_d ? d_rdata_o : if_rdata_o, g.we ? 32'h0 : e.rdata);
          chk("valid_cycle", cyc, e.vcyc);
          chk("bus_req_dropped", bus_req_o, 0);
          if (g.is_d) n_dv++;
        end
      end
      prev_req = bus_req_o;
    end
  end

  // Fetch requester
  initial begin
    bit keep;
    int bound;
    keep = 0; if_req_i = 0; if_addr_i = '0;
    wait (run_rand);
    for (int n = 0; n < NTX; n++) begin
      if (!keep) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
      end
      if_req_i  = 1;
      if_addr_i = (n == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
      bound = 0;
      do begin @(negedge clk); bound++; end while (!if_valid_o && bound < 200);
      if (bound >= 200) chk("if_wait_timeout", if_valid_o, 1);
      keep = ($urandom_range(0, 3) == 0) && (n < NTX - 1);
      if (!keep) if_req_i = 0;
    end
    if_done = 1;
  end

  // Data requester, then the request used for the reset-mid-transfer case
  initial begin
    bit keep;
    int bound;
    keep = 0; d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_wmask_i = '0;
    wait (run_rand);
    for (int n = 0; n < NTX; n++) begin
      if (!keep) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
      end
      d_req_i = 1;
      if (n == 0) begin
        d_we_i = 1; d_addr_i = 32'h2004; d_wdata_i = 32'hDEADBEEF; d_wmask_i = 4'b0011;
      end else if (n == 1) begin
        d_we_i = 0; d_addr_i = 32'h3000; d_wdata_i = $urandom; d_wmask_i = 4'($urandom);
      end else begin
        d_we_i = 1'($urandom); d_addr_i = $urandom; d_wdata_i = $urandom;
        d_wmask_i = 4'($urandom);
      end
      bound = 0;
      do begin @(negedge clk); bound++; end while (!d_valid_o && bound < 200);
      if (bound >= 200) chk("d_wait_timeout", d_valid_o, 1);
      keep = ($urandom_range(0, 3) == 0) && (n < NTX - 1);
      if (!keep) d_req_i = 0;
    end
    d_done = 1;
    wait (rst_phase);
    @(negedge clk);
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h3000;
    bound = 0;
    do begin @(negedge clk); bound++; end while (!(d_valid_o && reset_n) && bound < 200);
    if (bound >= 200) chk("rst_d_wait_timeout", d_valid_o, 1);
    d_req_i = 0;
  end

  // Sequencer: reset values, random traffic, reset during a data transfer
  initial begin
    int dv0;
    reset_n = 0; run_rand = 0; rst_phase = 0; slave_quiet = 0; if_done = 0; d_done = 0;
    n_checks = 0; n_err = 0; n_dv = 0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_bus_wdata", bus_wdata_o, 0);
    chk("rst_bus_ctl", {bus_we_o, bus_sel_o}, 0);
    chk("rst_valids", {if_valid_o, d_valid_o, err_o}, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    reset_n  = 1;
    run_rand = 1;
    for (int i = 0; i < 20000 && !(if_done && d_done); i++) @(negedge clk);
    chk("random_phase_done", {if_done, d_done}, 2'b11);
    repeat (15) @(negedge clk);
    chk("queues_drained", gnt_q.size() + exp_q.size(), 0);

    slave_quiet = 1;
    rst_phase   = 1;
    for (int i = 0; i < 50 && !bus_req_o; i++) @(negedge clk);
    chk("rst_phase_granted", bus_req_o, 1);
    chk("rst_phase_is_load", {bus_we_o, bus_addr_o[15:0]}, {1'b0, 16'h3000});
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("async_bus_req", bus_req_o, 0);
    chk("async_bus_addr", bus_addr_o, 0);
    chk("async_bus_ctl", {bus_we_o, bus_sel_o}, 0);
    chk("async_valids", {if_valid_o, d_valid_o, err_o}, 0);
    chk("async_d_rdata", d_rdata_o, 0);
    dv0 = n_dv;
    repeat (2) @(negedge clk);
    reset_n     = 1;
    slave_quiet = 0;
    for (int i = 0; i < 40 && n_dv == dv0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("rst_single_valid", n_dv - dv0, 1);
    chk("final_queues_drained", gnt_q.size() + exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
